nios2_mul_seq: RTL

Multiply sequencer that sits directly upstream of the NIOS2 32-bit multiply cell, a 1-cycle registered unit producing the low 32 bits of src1*src2. Accepts one multiply request at a time and drives the cell's operand ports. Returns either the low word (MUL) or, by issuing four zero-extended 16x16 passes and applying sign correction, the high word of the 64-bit product (MULXUU/MULXSU/MULXSS). The cell is instantiated by the parent; this block connects to it through the A_mul_* ports.

---
 rtl/nios2_mul_pkg.sv | 41 ++++
 rtl/nios2_mul_seq.sv | 138 +++++++++++++
 2 files changed

// File: rtl/nios2_mul_pkg.sv
// nios2_mul_pkg: shared types and constants for the multiply sequencer.
package nios2_mul_pkg;

   // Operation encoding on req_op.
   typedef enum logic [1:0] {
      OP_MUL    = 2'd0,
      OP_MULXUU = 2'd1,
      OP_MULXSU = 2'd2,
      OP_MULXSS = 2'd3
   } mul_op_e;

   // Sequencer states.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_LAST  = 3'd2,
      ST_CORR  = 3'd3,
      ST_DONE  = 3'd4
   } mul_state_e;

   // Number of 16x16 partial-product passes for a high-word multiply.
   localparam int NUM_PASSES = 4;

   // Accumulator alignment of each pass: lo*lo, hi*lo, lo*hi, hi*hi.
   localparam logic [5:0] SHIFT_P0 = 6'd0;
   localparam logic [5:0] SHIFT_P1 = 6'd16;
   localparam logic [5:0] SHIFT_P2 = 6'd16;
   localparam logic [5:0] SHIFT_P3 = 6'd32;

   function automatic logic [5:0] pass_shift(input logic [1:0] p);
      logic [5:0] sh;
      case (p)
         2'd0:    sh = SHIFT_P0;
         2'd1:    sh = SHIFT_P1;
         2'd2:    sh = SHIFT_P2;
         default: sh = SHIFT_P3;
      endcase
      return sh;
   endfunction

endpackage

// File: rtl/nios2_mul_seq.sv
// nios2_mul_seq: drives the external 1-cycle multiply cell, returning either
// the low product word directly or the signed/unsigned high word built from
// four zero-extended 16x16 passes plus a sign correction.
module nios2_mul_seq
   import nios2_mul_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [31:0] req_src1,
   input  logic [31:0] req_src2,
   input  logic        mul_abort,
   output logic [31:0] A_mul_src1,
   output logic [31:0] A_mul_src2,
   input  logic [31:0] A_mul_cell_result,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_data
);

   localparam logic [1:0] LAST_PASS = 2'(NUM_PASSES - 1);

   mul_state_e  state_q, state_d;
   logic [1:0]  p_q, p_d;
   mul_op_e     op_q, op_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [63:0] acc_q, acc_d;
   logic [31:0] res_q, res_d;
   logic [31:0] corr_hi;

   // Sign correction: unsigned high word minus the cross terms a signed
   // interpretation of a negative operand would subtract.
   always_comb begin
      corr_hi = acc_q[63:32];
      if ((op_q == OP_MULXSU || op_q == OP_MULXSS) && a_q[31])
         corr_hi = corr_hi - b_q;
      if (op_q == OP_MULXSS && b_q[31])
         corr_hi = corr_hi - a_q;
   end

   // Next-state, accumulation and cell operand selection.
   always_comb begin
      state_d    = state_q;
      p_d        = p_q;
      op_d       = op_q;
      a_d        = a_q;
      b_d        = b_q;
      acc_d      = acc_q;
      res_d      = res_q;
      A_mul_src1 = 32'd0;
      A_mul_src2 = 32'd0;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               op_d    = mul_op_e'(req_op);
               a_d     = req_src1;
               b_d     = req_src2;
               acc_d   = 64'd0;
               p_d     = 2'd0;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (op_q == OP_MUL) begin
               A_mul_src1 = a_q;
               A_mul_src2 = b_q;
               state_d    = ST_LAST;
            end else begin
               // Bit 0 of the pass index selects a's half, bit 1 selects b's.
               A_mul_src1 = {16'd0, p_q[0] ? a_q[31:16] : a_q[15:0]};
               A_mul_src2 = {16'd0, p_q[1] ? b_q[31:16] : b_q[15:0]};
               if (p_q != 2'd0)
                  acc_d = acc_q + ({32'd0, A_mul_cell_result} << pass_shift(p_q - 2'd1));
               if (p_q == LAST_PASS)
                  state_d = ST_LAST;
               else
                  p_d = p_q + 2'd1;
            end
         end
         ST_LAST: begin
            if (op_q == OP_MUL) begin
               res_d   = A_mul_cell_result;
               state_d = ST_DONE;
            end else begin
               acc_d   = acc_q + ({32'd0, A_mul_cell_result} << pass_shift(p_q));
               state_d = ST_CORR;
            end
         end
         ST_CORR: begin
            res_d   = corr_hi;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            if (res_ready)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Flush overrides everything, including a pending accept or result.
      if (mul_abort) begin
         state_d = ST_IDLE;
         p_d     = 2'd0;
         acc_d   = 64'd0;
         res_d   = res_q;
      end
   end

   // State and datapath registers, cleared together with the cell.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         p_q     <= 2'd0;
         op_q    <= OP_MUL;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         acc_q   <= 64'd0;
         res_q   <= 32'd0;
      end else begin
         state_q <= state_d;
         p_q     <= p_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         res_q   <= res_d;
      end
   end

   assign req_ready = (state_q == ST_IDLE);
   assign res_valid = (state_q == ST_DONE);
   assign res_data  = res_q;

endmodule
